// File: rtl/enet_nios_lcell_pkg.sv
// Shared definitions for the chained logic-cell block: operating-mode and
// output-mode encodings, legal width range, and small elaboration helpers.
package enet_nios_lcell_pkg;

  localparam int LCELL_MIN_WIDTH = 1;
  localparam int LCELL_MAX_WIDTH = 32;

  // How each cell computes its next value.
  typedef enum logic [1:0] {
    OP_NORMAL     = 2'd0,
    OP_ARITHMETIC = 2'd1,
    OP_COUNTER    = 2'd2,
    OP_ILLEGAL    = 2'd3
  } op_mode_e;

  // Which of the two result buses are live.
  typedef enum logic [1:0] {
    OUT_COMB_ONLY    = 2'd0,
    OUT_REG_ONLY     = 2'd1,
    OUT_COMB_AND_REG = 2'd2,
    OUT_ILLEGAL      = 2'd3
  } out_mode_e;

  // True when a chain length is one the block can build.
  function automatic bit width_legal(input int w);
    return (w >= LCELL_MIN_WIDTH) && (w <= LCELL_MAX_WIDTH);
  endfunction

endpackage

// File: rtl/enet_nios_lcell_chain_if.sv
// Data/control bundle of the logic-cell chain. The master side drives cell
// inputs and controls; the slave side (the chain) returns its results.
interface enet_nios_lcell_chain_if #(
  parameter int WIDTH = 8
);

  logic [WIDTH-1:0] dataa;
  logic [WIDTH-1:0] datab;
  logic [WIDTH-1:0] datac;
  logic [WIDTH-1:0] datad;
  logic             ena;
  logic             sclr;
  logic             sload;
  logic             updown;
  logic             cin;
  logic [WIDTH-1:0] combout;
  logic [WIDTH-1:0] regout;
  logic             cout;
  logic             cascout;

  modport master (
    output dataa, datab, datac, datad,
    output ena, sclr, sload, updown, cin,
    input  combout, regout, cout, cascout
  );

  modport slave (
    input  dataa, datab, datac, datad,
    input  ena, sclr, sload, updown, cin,
    output combout, regout, cout, cascout
  );

endinterface

// File: rtl/enet_nios_lcell_lut.sv
// One 4-input look-up table. The truth table is fixed at elaboration and
// addressed as {datad, datac, datab, dataa}.
module enet_nios_lcell_lut #(
  parameter logic [15:0] MASK = 16'hFFFF
) (
  input  logic i_dataa,
  input  logic i_datab,
  input  logic i_datac,
  input  logic i_datad,
  output logic o_lut
);

  logic [3:0] w_addr;

  assign w_addr = {i_datad, i_datac, i_datab, i_dataa};
  assign o_lut  = MASK[w_addr];

endmodule

// File: rtl/enet_nios_lcell_chain.sv
// A WIDTH-cell logic-cell chain. Every cell has a LUT, a ripple carry stage
// and a result register; the operating mode selects whether the chain acts as
// a bank of LUTs, an adder, or an up/down counter.
module enet_nios_lcell_chain
  import enet_nios_lcell_pkg::*;
#(
  parameter int          WIDTH          = 8,
  parameter logic [15:0] LUT_MASK       = 16'hFFFF,
  parameter string       OPERATION_MODE = "counter",
  parameter string       OUTPUT_MODE    = "comb_and_reg",
  parameter string       POWER_UP       = "low",
  parameter string       CIN_USED       = "false",
  parameter string       CASCADE_USED   = "false"
) (
  input logic                   clk,
  input logic                   reset,
  enet_nios_lcell_chain_if.slave bus
);

  // String parameters are decoded once into enums and flags; anything that
  // does not decode lands in an ILLEGAL encoding and stops elaboration below.
  localparam op_mode_e OP_MODE =
      (OPERATION_MODE == "normal")     ? OP_NORMAL     :
      (OPERATION_MODE == "arithmetic") ? OP_ARITHMETIC :
      (OPERATION_MODE == "counter")    ? OP_COUNTER    : OP_ILLEGAL;

  localparam out_mode_e OUT_MODE =
      (OUTPUT_MODE == "comb_only")    ? OUT_COMB_ONLY    :
      (OUTPUT_MODE == "reg_only")     ? OUT_REG_ONLY     :
      (OUTPUT_MODE == "comb_and_reg") ? OUT_COMB_AND_REG : OUT_ILLEGAL;

  localparam bit POWER_LEGAL   = (POWER_UP == "low") || (POWER_UP == "high");
  localparam bit POWER_HIGH    = (POWER_UP == "high");
  localparam bit CIN_LEGAL     = (CIN_USED == "true") || (CIN_USED == "false");
  localparam bit CIN_EN        = (CIN_USED == "true");
  localparam bit CASCADE_LEGAL = (CASCADE_USED == "true") || (CASCADE_USED == "false");
  localparam bit CASCADE_EN    = (CASCADE_USED == "true");

  localparam logic [WIDTH-1:0] RESET_VAL = POWER_HIGH ? {WIDTH{1'b1}} : {WIDTH{1'b0}};

  // Elaboration guards: a bad configuration must never build silently.
  if (!width_legal(WIDTH)) begin : g_bad_width
    $error("enet_nios_lcell_chain: WIDTH=%0d outside %0d..%0d",
           WIDTH, LCELL_MIN_WIDTH, LCELL_MAX_WIDTH);
  end
  if (OP_MODE == OP_ILLEGAL) begin : g_bad_op
    $error("enet_nios_lcell_chain: unknown OPERATION_MODE");
  end
  if (OUT_MODE == OUT_ILLEGAL) begin : g_bad_out
    $error("enet_nios_lcell_chain: unknown OUTPUT_MODE");
  end
  if (!POWER_LEGAL) begin : g_bad_power
    $error("enet_nios_lcell_chain: POWER_UP must be low or high");
  end
  if (!CIN_LEGAL) begin : g_bad_cin
    $error("enet_nios_lcell_chain: CIN_USED must be true or false");
  end
  if (!CASCADE_LEGAL) begin : g_bad_cascade
    $error("enet_nios_lcell_chain: CASCADE_USED must be true or false");
  end

  logic [WIDTH-1:0] w_lut;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH:0]   w_carry;
  logic [WIDTH-1:0] w_stepVec;
  logic [WIDTH-1:0] w_cntNext;
  logic [WIDTH-1:0] w_next;
  logic             w_c0;
  logic             w_step;
  logic             w_cntCout;
  logic             w_cout;
  logic [WIDTH-1:0] r_reg;

  // Carry into cell 0 of the adder, and the counter step size. Without an
  // external carry-in the counter always steps by one.
  assign w_c0      = CIN_EN ? bus.cin : 1'b0;
  assign w_step    = CIN_EN ? bus.cin : 1'b1;
  assign w_stepVec = WIDTH'(w_step);
  assign w_carry[0] = w_c0;

  // Per-cell LUT plus one ripple-carry stage.
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    enet_nios_lcell_lut #(
      .MASK (LUT_MASK)
    ) u_lut (
      .i_dataa (bus.dataa[i]),
      .i_datab (bus.datab[i]),
      .i_datac (bus.datac[i]),
      .i_datad (bus.datad[i]),
      .o_lut   (w_lut[i])
    );

    assign w_sum[i]       = bus.dataa[i] ^ bus.datab[i] ^ w_carry[i];
    assign w_carry[i + 1] = (bus.dataa[i] & bus.datab[i]) |
                            (w_carry[i] & (bus.dataa[i] ^ bus.datab[i]));
  end

  // Counter wraps in both directions; cout flags the wrap about to happen.
  assign w_cntNext = bus.updown ? (r_reg + w_stepVec) : (r_reg - w_stepVec);
  assign w_cntCout = w_step & (bus.updown ? (&r_reg) : ~(|r_reg));

  // Select the per-mode next value and carry-out; normal mode never carries.
  always_comb begin
    w_next = w_lut;
    w_cout = 1'b0;
    case (OP_MODE)
      OP_ARITHMETIC: begin
        w_next = w_sum;
        w_cout = w_carry[WIDTH];
      end
      OP_COUNTER: begin
        w_next = w_cntNext;
        w_cout = w_cntCout;
      end
      default: begin
        w_next = w_lut;
        w_cout = 1'b0;
      end
    endcase
  end

  // Result register: reset wins asynchronously, then clear, load, enable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_reg <= RESET_VAL;
    end else if (bus.sclr) begin
      r_reg <= '0;
    end else if (bus.sload) begin
      r_reg <= bus.dataa;
    end else if (bus.ena) begin
      r_reg <= w_next;
    end
  end

  // The counter still needs its state internally in comb_only mode; only the
  // visible regout bus is silenced there.
  assign bus.combout = (OUT_MODE == OUT_REG_ONLY)  ? '0 : w_next;
  assign bus.regout  = (OUT_MODE == OUT_COMB_ONLY) ? '0 : r_reg;
  assign bus.cout    = w_cout;
  assign bus.cascout = CASCADE_EN ? (&w_lut) : 1'b1;

endmodule

// File: tb/tb_enet_nios_lcell_chain.sv
// Directed bench for the logic-cell chain: four configurations (counter,
// arithmetic with carry-in, normal with cascade, counter powering up high).
module tb_enet_nios_lcell_chain;

  logic clk;
  logic reset;
  int   checkCount;
  int   passCount;

  enet_nios_lcell_chain_if #(.WIDTH(8)) cntIf ();
  enet_nios_lcell_chain_if #(.WIDTH(8)) arithIf ();
  enet_nios_lcell_chain_if #(.WIDTH(8)) normIf ();
  enet_nios_lcell_chain_if #(.WIDTH(8)) highIf ();

  enet_nios_lcell_chain #(
    .WIDTH (8)
  ) u_cnt (
    .clk   (clk),
    .reset (reset),
    .bus   (cntIf)
  );

  enet_nios_lcell_chain #(
    .WIDTH          (8),
    .OPERATION_MODE ("arithmetic"),
    .CIN_USED       ("true")
  ) u_arith (
    .clk   (clk),
    .reset (reset),
    .bus   (arithIf)
  );

  enet_nios_lcell_chain #(
    .WIDTH          (8),
    .LUT_MASK       (16'h8000),
    .OPERATION_MODE ("normal"),
    .CASCADE_USED   ("true")
  ) u_norm (
    .clk   (clk),
    .reset (reset),
    .bus   (normIf)
  );

  enet_nios_lcell_chain #(
    .WIDTH    (8),
    .POWER_UP ("high")
  ) u_high (
    .clk   (clk),
    .reset (reset),
    .bus   (highIf)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    cntIf.dataa = 8'h00;   cntIf.datab = 8'h00;   cntIf.datac = 8'h00;   cntIf.datad = 8'h00;
    cntIf.ena = 0; cntIf.sclr = 0; cntIf.sload = 0; cntIf.updown = 0; cntIf.cin = 0;
    arithIf.dataa = 8'h00; arithIf.datab = 8'h00; arithIf.datac = 8'h00; arithIf.datad = 8'h00;
    arithIf.ena = 0; arithIf.sclr = 0; arithIf.sload = 0; arithIf.updown = 0; arithIf.cin = 0;
    normIf.dataa = 8'h00;  normIf.datab = 8'h00;  normIf.datac = 8'h00;  normIf.datad = 8'h00;
    normIf.ena = 0; normIf.sclr = 0; normIf.sload = 0; normIf.updown = 0; normIf.cin = 0;
    highIf.dataa = 8'h00;  highIf.datab = 8'h00;  highIf.datac = 8'h00;  highIf.datad = 8'h00;
    highIf.ena = 0; highIf.sclr = 0; highIf.sload = 0; highIf.updown = 0; highIf.cin = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_inputs();
    #2;
    checkCount++;
    if (cntIf.regout !== 8'h00) $display("[TB] FAIL reset_cnt_regout: got %h expected %h", cntIf.regout, 8'h00);
    else passCount++;
    checkCount++;
    if (highIf.regout !== 8'hFF) $display("[TB] FAIL reset_high_regout: got %h expected %h", highIf.regout, 8'hFF);
    else passCount++;
    checkCount++;
    if (cntIf.combout !== 8'hFF) $display("[TB] FAIL reset_cnt_down_combout: got %h expected %h", cntIf.combout, 8'hFF);
    else passCount++;
    checkCount++;
    if (cntIf.cout !== 1'b1) $display("[TB] FAIL reset_cnt_down_cout: got %b expected %b", cntIf.cout, 1'b1);
    else passCount++;
    checkCount++;
    if (normIf.cascout !== 1'b0) $display("[TB] FAIL reset_norm_cascout: got %b expected %b", normIf.cascout, 1'b0);
    else passCount++;
    checkCount++;
    if (arithIf.cascout !== 1'b1) $display("[TB] FAIL reset_arith_cascout_unused: got %b expected %b", arithIf.cascout, 1'b1);
    else passCount++;
    // Load and enable under reset must not disturb the power-up value.
    highIf.dataa = 8'h55;
    highIf.sload = 1'b1;
    highIf.ena   = 1'b1;
    @(posedge clk);
    #1;
    checkCount++;
    if (highIf.regout !== 8'hFF) $display("[TB] FAIL reset_high_ignores_sload: got %h expected %h", highIf.regout, 8'hFF);
    else passCount++;
    @(negedge clk);
    highIf.sload = 1'b0;
    highIf.ena   = 1'b0;
    reset = 1'b0;
    #1;
    checkCount++;
    if (highIf.regout !== 8'hFF) $display("[TB] FAIL reset_high_after_release: got %h expected %h", highIf.regout, 8'hFF);
    else passCount++;
  endtask

  task automatic test_count_up();
    cntIf.updown = 1'b1;
    cntIf.ena    = 1'b1;
    #1;
    for (int i = 0; i < 256; i++) begin
      checkCount++;
      if (cntIf.regout !== 8'(i)) $display("[TB] FAIL count_up_regout[%0d]: got %h expected %h", i, cntIf.regout, 8'(i));
      else passCount++;
      checkCount++;
      if (cntIf.cout !== (i == 255)) $display("[TB] FAIL count_up_cout[%0d]: got %b expected %b", i, cntIf.cout, (i == 255));
      else passCount++;
      checkCount++;
      if (cntIf.combout !== 8'(i + 1)) $display("[TB] FAIL count_up_combout[%0d]: got %h expected %h", i, cntIf.combout, 8'(i + 1));
      else passCount++;
      @(posedge clk);
      @(negedge clk);
    end
    checkCount++;
    if (cntIf.regout !== 8'h00) $display("[TB] FAIL count_up_wrap: got %h expected %h", cntIf.regout, 8'h00);
    else passCount++;
    cntIf.ena = 1'b0;
  endtask

  task automatic test_count_down();
    logic [7:0] expSeq [5];
    expSeq = '{8'h03, 8'h02, 8'h01, 8'h00, 8'hFF};
    cntIf.dataa = 8'h03;
    cntIf.sload = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cntIf.sload  = 1'b0;
    cntIf.ena    = 1'b1;
    cntIf.updown = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      checkCount++;
      if (cntIf.regout !== expSeq[k]) $display("[TB] FAIL count_down_regout[%0d]: got %h expected %h", k, cntIf.regout, expSeq[k]);
      else passCount++;
      checkCount++;
      if (cntIf.cout !== (expSeq[k] == 8'h00)) $display("[TB] FAIL count_down_cout[%0d]: got %b expected %b", k, cntIf.cout, (expSeq[k] == 8'h00));
      else passCount++;
      if (k < 4) begin
        @(posedge clk);
        @(negedge clk);
      end
    end
    cntIf.ena = 1'b0;
  endtask

  task automatic test_priority();
    cntIf.sclr   = 1'b1;
    cntIf.sload  = 1'b1;
    cntIf.ena    = 1'b1;
    cntIf.updown = 1'b1;
    cntIf.dataa  = 8'h55;
    @(posedge clk);
    @(negedge clk);
    checkCount++;
    if (cntIf.regout !== 8'h00) $display("[TB] FAIL prio_sclr_wins: got %h expected %h", cntIf.regout, 8'h00);
    else passCount++;
    cntIf.sclr = 1'b0;
    cntIf.ena  = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkCount++;
    if (cntIf.regout !== 8'h55) $display("[TB] FAIL prio_sload_no_ena: got %h expected %h", cntIf.regout, 8'h55);
    else passCount++;
    cntIf.ena   = 1'b1;
    cntIf.dataa = 8'hAA;
    @(posedge clk);
    @(negedge clk);
    checkCount++;
    if (cntIf.regout !== 8'hAA) $display("[TB] FAIL prio_sload_beats_ena: got %h expected %h", cntIf.regout, 8'hAA);
    else passCount++;
    cntIf.sload = 1'b0;
    cntIf.ena   = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkCount++;
    if (cntIf.regout !== 8'hAA) $display("[TB] FAIL prio_hold: got %h expected %h", cntIf.regout, 8'hAA);
    else passCount++;
  endtask

  task automatic test_arith();
    logic [7:0] vecA   [5];
    logic [7:0] vecB   [5];
    logic       vecCin [5];
    logic [7:0] vecSum [5];
    logic       vecCo  [5];
    vecA   = '{8'h12, 8'hF0, 8'h7F, 8'h80, 8'hFF};
    vecB   = '{8'h34, 8'h0F, 8'h01, 8'h80, 8'hFF};
    vecCin = '{1'b0,  1'b1,  1'b1,  1'b0,  1'b1};
    vecSum = '{8'h46, 8'h00, 8'h81, 8'h00, 8'hFF};
    vecCo  = '{1'b0,  1'b1,  1'b0,  1'b1,  1'b1};
    arithIf.ena = 1'b1;
    for (int v = 0; v < 5; v++) begin
      arithIf.dataa = vecA[v];
      arithIf.datab = vecB[v];
      arithIf.cin   = vecCin[v];
      #1;
      checkCount++;
      if (arithIf.combout !== vecSum[v]) $display("[TB] FAIL arith_combout[%0d]: got %h expected %h", v, arithIf.combout, vecSum[v]);
      else passCount++;
      checkCount++;
      if (arithIf.cout !== vecCo[v]) $display("[TB] FAIL arith_cout[%0d]: got %b expected %b", v, arithIf.cout, vecCo[v]);
      else passCount++;
      @(posedge clk);
      @(negedge clk);
      checkCount++;
      if (arithIf.regout !== vecSum[v]) $display("[TB] FAIL arith_regout[%0d]: got %h expected %h", v, arithIf.regout, vecSum[v]);
      else passCount++;
    end
    arithIf.ena = 1'b0;
  endtask

  task automatic test_normal();
    normIf.dataa = 8'hFF;
    normIf.datab = 8'hFF;
    normIf.datac = 8'hFF;
    normIf.datad = 8'hFF;
    #1;
    checkCount++;
    if (normIf.combout !== 8'hFF) $display("[TB] FAIL norm_all_ones_combout: got %h expected %h", normIf.combout, 8'hFF);
    else passCount++;
    checkCount++;
    if (normIf.cascout !== 1'b1) $display("[TB] FAIL norm_all_ones_cascout: got %b expected %b", normIf.cascout, 1'b1);
    else passCount++;
    checkCount++;
    if (normIf.cout !== 1'b0) $display("[TB] FAIL norm_cout: got %b expected %b", normIf.cout, 1'b0);
    else passCount++;
    normIf.datad = 8'hF7;
    #1;
    checkCount++;
    if (normIf.combout !== 8'hF7) $display("[TB] FAIL norm_d3_clear_combout: got %h expected %h", normIf.combout, 8'hF7);
    else passCount++;
    checkCount++;
    if (normIf.cascout !== 1'b0) $display("[TB] FAIL norm_d3_clear_cascout: got %b expected %b", normIf.cascout, 1'b0);
    else passCount++;
    normIf.ena = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkCount++;
    if (normIf.regout !== 8'hF7) $display("[TB] FAIL norm_regout: got %h expected %h", normIf.regout, 8'hF7);
    else passCount++;
    normIf.ena   = 1'b0;
    normIf.datad = 8'hFF;
    normIf.dataa = 8'h0F;
    #1;
    checkCount++;
    if (normIf.combout !== 8'h0F) $display("[TB] FAIL norm_dataa_nibble_combout: got %h expected %h", normIf.combout, 8'h0F);
    else passCount++;
  endtask

  task automatic test_powerup_high();
    @(negedge clk);
    highIf.dataa = 8'h20;
    highIf.sload = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkCount++;
    if (highIf.regout !== 8'h20) $display("[TB] FAIL high_load_20: got %h expected %h", highIf.regout, 8'h20);
    else passCount++;
    highIf.sload  = 1'b0;
    highIf.ena    = 1'b1;
    highIf.updown = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    checkCount++;
    if (highIf.regout !== 8'hFF) $display("[TB] FAIL high_async_reset: got %h expected %h", highIf.regout, 8'hFF);
    else passCount++;
    @(posedge clk);
    #1;
    checkCount++;
    if (highIf.regout !== 8'hFF) $display("[TB] FAIL high_reset_held: got %h expected %h", highIf.regout, 8'hFF);
    else passCount++;
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkCount++;
    if (highIf.regout !== 8'hFF) $display("[TB] FAIL high_release_no_edge: got %h expected %h", highIf.regout, 8'hFF);
    else passCount++;
    @(posedge clk);
    @(negedge clk);
    checkCount++;
    if (highIf.regout !== 8'h00) $display("[TB] FAIL high_resume_wrap: got %h expected %h", highIf.regout, 8'h00);
    else passCount++;
    @(posedge clk);
    @(negedge clk);
    checkCount++;
    if (highIf.regout !== 8'h01) $display("[TB] FAIL high_resume_count: got %h expected %h", highIf.regout, 8'h01);
    else passCount++;
    highIf.ena = 1'b0;
  endtask

  // Scenario sequence; each task leaves the bench just after a falling edge.
  initial begin
    checkCount = 0;
    passCount  = 0;
    test_reset();
    test_count_up();
    test_count_down();
    test_priority();
    test_arith();
    test_normal();
    test_powerup_high();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/enet_nios_lcell_chain.md
ENET_NIOS_LCELL_CHAIN -- requirements
Module: enet_nios_lcell_chain

Interface
REQ-001 Parameter WIDTH, default 8, number of chained logic cells (1..32).
REQ-002 Parameter LUT_MASK, default 16'hFFFF, 4-input truth table applied to every cell in normal mode; bit index = {datad,datac,datab,dataa}.
REQ-003 Parameter OPERATION_MODE, default "counter", one of "normal", "arithmetic", "counter".
REQ-004 Parameter OUTPUT_MODE, default "comb_and_reg", one of "comb_only", "reg_only", "comb_and_reg".
REQ-005 Parameter POWER_UP, default "low", register reset value: "low" = all zeros, "high" = all ones.
REQ-006 Parameter CIN_USED, default "false"; when "true", cin enters cell 0 of the carry chain.
REQ-007 Parameter CASCADE_USED, default "false"; when "true", cascout is the AND-chain of all cell LUT results.
REQ-008 Port clk  in  1  single clock; all registers update on its rising edge.
REQ-009 Port reset  in  1  asynchronous, active-high reset.
REQ-010 Ports dataa, datab, datac, datad  in  WIDTH  per-cell LUT/adder inputs.
REQ-011 Ports ena, sclr, sload, updown, cin  in  1  register enable, synchronous clear, synchronous load, count direction (1 = up), carry-in.
REQ-012 Ports combout, regout  out  WIDTH  combinational and registered cell results.
REQ-013 Ports cout, cascout  out  1  carry/borrow out of the top cell, cascade result.

Function
REQ-014 Normal mode: lut[i] SHALL equal LUT_MASK[{datad[i],datac[i],datab[i],dataa[i]}]; combout = lut; next register value = lut.
REQ-015 Arithmetic mode: combout SHALL equal (dataa + datab + c0) modulo 2^WIDTH, c0 = cin if CIN_USED else 0; cout = carry out of bit WIDTH-1; next register value = combout.
REQ-016 Counter mode: step s = cin if CIN_USED else 1; next value = regout + s when updown=1, regout - s when updown=0, modulo 2^WIDTH; combout = that next value.
REQ-017 Counter mode cout SHALL be 1 when s=1 and (updown=1 and regout all ones, or updown=0 and regout zero); else 0; no saturation, counter wraps.
REQ-018 Register update priority per clock edge: sclr (load zeros) > sload (load dataa) > ena (load next value) > hold; sclr/sload act regardless of ena.
REQ-019 Latency: regout reflects the selected value one clock after the edge sampling the controls; combout zero-latency.
REQ-020 OUTPUT_MODE "comb_only": regout driven 0, register unused; "reg_only": combout driven 0.
REQ-021 cascout SHALL be AND of lut[WIDTH-1:0] when CASCADE_USED, else 1.
REQ-022 In normal mode cout SHALL be 0.
REQ-023 Illegal parameter values SHALL be rejected at elaboration (generate-time error).

Reset
REQ-024 reset=1 SHALL immediately force regout to POWER_UP value, independent of clk, ena, sclr, sload.
REQ-025 Reset mid-count: register held at POWER_UP value while reset=1; counting resumes from it on the first edge after deassertion.
REQ-026 combout, cout, cascout are combinational and SHALL NOT depend on reset except through regout.

Structure
REQ-027 Mode and output-mode encodings plus WIDTH limits SHALL live in package enet_nios_lcell_pkg.
REQ-028 One sub-module enet_nios_lcell_lut (single 4-input LUT with mask parameter) SHALL be instantiated WIDTH times via generate.
REQ-029 Carry chain, register and control priority SHALL be in the top module; no vendor primitives.

Verification
REQ-030 Counter, WIDTH=8, POWER_UP low, ena=1, updown=1 from reset for 256 clocks -> regout 0..255 then 0; cout=1 only while regout=8'hFF.
REQ-031 Counter down, sload=1 with dataa=8'h03 then ena=1, updown=0 -> regout 03,02,01,00,FF; cout=1 while regout=00.
REQ-032 Same edge sclr=1, sload=1, ena=1, dataa=8'h55 -> regout=00; next edge sload only -> regout=55.
REQ-033 Arithmetic, CIN_USED true, dataa=8'hF0, datab=8'h0F, cin=1 -> combout=00, cout=1; after one enabled edge regout=00.
REQ-034 Normal, LUT_MASK=16'h8000, CASCADE_USED true, all inputs 8'hFF -> combout=FF, cascout=1; clear datad[3] -> combout=F7, cascout=0.
REQ-035 POWER_UP high, counting at regout=8'h20, assert reset asynchronously between edges -> regout=FF immediately; release, ena=1 up -> 00 on next edge.
